// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: the bubble instruction, control-flow opcodes
// and the {PC, instruction} entry stored per slot.
package fetch_pkg;

   localparam int          FQ_XLEN    = 32;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;   // addi x0, x0, 0
   localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
   localparam logic [6:0]  OPC_JALR   = 7'b110_0111;
   localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] inst;
   } fq_entry_t;

   function automatic logic is_ctrl_flow(input logic [31:0] inst);
      return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR) || (inst[6:0] == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one write port, asynchronous read mux.
// No reset: whether a slot holds live data is decided by the occupancy count in the top level.
module fq_storage
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [PTR_W-1:0] wr_ptr_i,
   input  fq_entry_t        wr_data_i,
   input  logic [PTR_W-1:0] rd_ptr_i,
   output fq_entry_t        rd_data_o
);

   fq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry fetch->decode instruction queue with NOP-padded head output and whole-queue kill.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for a zero-latency fetch->decode path when empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN  = 32,
   parameter int              DEPTH = 4,
   parameter logic [XLEN-1:0] NOP   = NOP_INST
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [XLEN-1:0]            PC_f,
   input  logic [XLEN-1:0]            inst_f,
   input  logic                       stall,
   input  logic                       kill_dx,
   output logic                       valid_d,
   output logic [XLEN-1:0]            PC_d,
   output logic [XLEN-1:0]            inst_d,
   output logic [4:0]                 addr_rs1,
   output logic [4:0]                 addr_rs2,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic      head_valid;
   logic      bypass_hit;
   logic      wr_en;
   logic      rd_en;
   fq_entry_t wr_entry;
   fq_entry_t rd_entry;

   assign head_valid = (count_q != '0);
   assign push_ready = (count_q != FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass_hit = rst_n & ~kill_dx & push_valid & ~head_valid;
`else
   assign bypass_hit = 1'b0;
`endif

   // A bypassed instruction that decode takes this cycle is never written.
   assign wr_en = rst_n & push_valid & push_ready & ~kill_dx & ~(bypass_hit & ~stall);
   assign rd_en = head_valid & ~stall & ~kill_dx;

   assign wr_entry = '{pc: PC_f, inst: inst_f};

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_ptr_i  (wr_ptr_q),
      .wr_data_i (wr_entry),
      .rd_ptr_i  (rd_ptr_q),
      .rd_data_o (rd_entry)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Kill behaves as a synchronous clear of the control state; entry contents are left stale.
   always_ff @(posedge clk) begin
      if (!rst_n || kill_dx) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      valid_d = 1'b0;
      PC_d    = '0;
      inst_d  = NOP;
      if (head_valid) begin
         valid_d = 1'b1;
         PC_d    = rd_entry.pc;
         inst_d  = rd_entry.inst;
      end else if (bypass_hit) begin
         valid_d = 1'b1;
         PC_d    = PC_f;
         inst_d  = inst_f;
      end
   end

   assign addr_rs1 = inst_d[19:15];
   assign addr_rs2 = inst_d[24:20];
   assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue scoreboard tracks accepted pushes and is compared
// against the head outputs every cycle. Bypass checks run only when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] PC_f;
   logic [31:0] inst_f;
   logic        stall;
   logic        kill_dx;
   logic        valid_d;
   logic [31:0] PC_d;
   logic [31:0] inst_d;
   logic [4:0]  addr_rs1;
   logic [4:0]  addr_rs2;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .XLEN  (32),
      .DEPTH (DEPTH),
      .NOP   (NOP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .PC_f       (PC_f),
      .inst_f     (inst_f),
      .stall      (stall),
      .kill_dx    (kill_dx),
      .valid_d    (valid_d),
      .PC_d       (PC_d),
      .inst_d     (inst_d),
      .addr_rs1   (addr_rs1),
      .addr_rs2   (addr_rs2),
      .count      (count)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
      return (exp_q.size() == 0) && push_valid && !kill_dx && rst_n;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic exp_valid();
      return (exp_q.size() != 0) || bypass_now();
   endfunction

   function automatic logic [31:0] exp_pc();
      if (exp_q.size() != 0) return exp_q[0].pc;
      if (bypass_now()) return PC_f;
      return 32'h0;
   endfunction

   function automatic logic [31:0] exp_inst();
      if (exp_q.size() != 0) return exp_q[0].inst;
      if (bypass_now()) return inst_f;
      return NOP;
   endfunction

   function automatic logic [31:0] mk_inst(input int i);
      logic [31:0] v;
      v = {7'h00, 5'(i + 3), 5'(i + 1), 3'b000, 5'(i), 7'h13};
      return v;
   endfunction

   task automatic apply(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic kl);
      push_valid = pv;
      PC_f       = pc;
      inst_f     = inst;
      stall      = st;
      kill_dx    = kl;
      #1;
   endtask

   // Advance one clock, updating the scoreboard with what the edge should do.
   task automatic step();
      logic byp, do_pop, do_push;
      if (!rst_n || kill_dx) begin
         exp_q.delete();
      end else begin
         byp     = bypass_now() && !stall;
         do_pop  = (exp_q.size() != 0) && !stall;
         do_push = push_valid && (exp_q.size() != DEPTH) && !byp;
         if (do_pop) begin
            $display("pop    pc=%08h inst=%08h", exp_q[0].pc, exp_q[0].inst);
            void'(exp_q.pop_front());
         end
         if (byp) $display("bypass pc=%08h inst=%08h", PC_f, inst_f);
         if (do_push) begin
            exp_q.push_back('{pc: PC_f, inst: inst_f});
            $display("push   pc=%08h inst=%08h", PC_f, inst_f);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply(1'b1, 32'hdead_0000, 32'h0010_0093, 1'b0, 1'b0);
      step();
      step();
      total++;
      if ({valid_d, PC_d, inst_d, addr_rs1, addr_rs2, count, push_ready} !==
          {1'b0, 32'h0, NOP, 5'd0, 5'd0, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_values: got v=%0b pc=%08h inst=%08h rs1=%0d rs2=%0d cnt=%0d rdy=%0b want v=0 pc=0 inst=%08h rs1=0 rs2=0 cnt=0 rdy=1",
                  valid_d, PC_d, inst_d, addr_rs1, addr_rs2, count, push_ready, NOP);
      end
      rst_n = 1'b1;
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if (count !== 3'd0 || valid_d !== 1'b0) begin
         bad++;
         $display("FAIL reset_push_ignored: got cnt=%0d v=%0b want cnt=0 v=0", count, valid_d);
      end
   endtask

   task automatic test_single();
      logic [31:0] ei;
      apply(1'b1, 32'h0000_1000, 32'h0050_0093, 1'b0, 1'b0);
      ei = exp_inst();
      total++;
      if ({valid_d, PC_d, inst_d} !== {exp_valid(), exp_pc(), ei}) begin
         bad++;
         $display("FAIL single_push_cycle: got v=%0b pc=%08h inst=%08h want v=%0b pc=%08h inst=%08h",
                  valid_d, PC_d, inst_d, exp_valid(), exp_pc(), ei);
      end
      step();
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, PC_d, inst_d, addr_rs1, addr_rs2} !==
          {1'b1, 32'h0000_1000, 32'h0050_0093, 5'd0, 5'd5}) begin
         bad++;
         $display("FAIL single_head: got v=%0b pc=%08h inst=%08h rs1=%0d rs2=%0d want v=1 pc=00001000 inst=00500093 rs1=0 rs2=5",
                  valid_d, PC_d, inst_d, addr_rs1, addr_rs2);
      end
      step();
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, PC_d, inst_d, count} !== {1'b0, 32'h0, NOP, 3'd0}) begin
         bad++;
         $display("FAIL single_bubble: got v=%0b pc=%08h inst=%08h cnt=%0d want v=0 pc=0 inst=%08h cnt=0",
                  valid_d, PC_d, inst_d, count, NOP);
      end
   endtask

   task automatic test_full_stall();
      logic [31:0] ei;
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 32'h0000_2000 + 32'(4 * i), mk_inst(i), 1'b1, 1'b0);
         ei = exp_inst();
         total++;
         if ({push_ready, valid_d, PC_d, inst_d, count} !==
             {(exp_q.size() != DEPTH), exp_valid(), exp_pc(), ei, 3'(exp_q.size())}) begin
            bad++;
            $display("FAIL stall_fill[%0d]: got rdy=%0b v=%0b pc=%08h inst=%08h cnt=%0d want rdy=%0b v=%0b pc=%08h inst=%08h cnt=%0d",
                     i, push_ready, valid_d, PC_d, inst_d, count,
                     (exp_q.size() != DEPTH), exp_valid(), exp_pc(), ei, exp_q.size());
         end
         step();
      end
      apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      total++;
      if ({count, push_ready, PC_d} !== {3'd4, 1'b0, 32'h0000_2000}) begin
         bad++;
         $display("FAIL stall_full: got cnt=%0d rdy=%0b pc=%08h want cnt=4 rdy=0 pc=00002000",
                  count, push_ready, PC_d);
      end
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         ei = exp_inst();
         total++;
         if ({push_ready, valid_d, PC_d, inst_d, addr_rs1, addr_rs2} !==
             {(i != 0), exp_valid(), exp_pc(), ei, ei[19:15], ei[24:20]}) begin
            bad++;
            $display("FAIL drain[%0d]: got rdy=%0b v=%0b pc=%08h inst=%08h rs1=%0d rs2=%0d want rdy=%0b v=%0b pc=%08h inst=%08h rs1=%0d rs2=%0d",
                     i, push_ready, valid_d, PC_d, inst_d, addr_rs1, addr_rs2,
                     (i != 0), exp_valid(), exp_pc(), ei, ei[19:15], ei[24:20]);
         end
         step();
      end
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, count} !== {1'b0, 3'd0}) begin
         bad++;
         $display("FAIL drain_empty: got v=%0b cnt=%0d want v=0 cnt=0", valid_d, count);
      end
   endtask

   task automatic test_kill();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 32'h0000_3000 + 32'(4 * i), mk_inst(i + 8), 1'b1, 1'b0);
         step();
      end
      apply(1'b1, 32'h0000_3100, mk_inst(20), 1'b1, 1'b1);
      total++;
      if ({count, valid_d, PC_d} !== {3'd3, 1'b1, 32'h0000_3000}) begin
         bad++;
         $display("FAIL kill_before: got cnt=%0d v=%0b pc=%08h want cnt=3 v=1 pc=00003000",
                  count, valid_d, PC_d);
      end
      step();
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({count, valid_d, PC_d, inst_d} !== {3'd0, 1'b0, 32'h0, NOP}) begin
         bad++;
         $display("FAIL kill_after: got cnt=%0d v=%0b pc=%08h inst=%08h want cnt=0 v=0 pc=0 inst=%08h",
                  count, valid_d, PC_d, inst_d, NOP);
      end
      step();
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({count, valid_d} !== {3'd0, 1'b0}) begin
         bad++;
         $display("FAIL kill_dropped_push: got cnt=%0d v=%0b pc=%08h want cnt=0 v=0", count, valid_d, PC_d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ei;
      apply(1'b1, 32'h0000_4000, mk_inst(1), 1'b0, 1'b0);
      step();
      for (int i = 1; i <= 10; i++) begin
         apply(1'b1, 32'h0000_4000 + 32'(4 * i), mk_inst(i + 1), 1'b0, 1'b0);
         ei = exp_inst();
         total++;
         if ({count, valid_d, PC_d, inst_d} !== {3'd1, exp_valid(), exp_pc(), ei}) begin
            bad++;
            $display("FAIL b2b[%0d]: got cnt=%0d v=%0b pc=%08h inst=%08h want cnt=1 v=%0b pc=%08h inst=%08h",
                     i, count, valid_d, PC_d, inst_d, exp_valid(), exp_pc(), ei);
         end
         step();
      end
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, PC_d} !== {1'b1, 32'h0000_4028}) begin
         bad++;
         $display("FAIL b2b_last: got v=%0b pc=%08h want v=1 pc=00004028", valid_d, PC_d);
      end
      step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 32'h0000_5000 + 32'(4 * i), mk_inst(i + 4), 1'b1, 1'b0);
         step();
      end
      rst_n = 1'b0;
      apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      total++;
      if (count !== 3'd2) begin
         bad++;
         $display("FAIL rst_mid_before: got cnt=%0d want cnt=2", count);
      end
      step();
      rst_n = 1'b1;
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, PC_d, inst_d, addr_rs1, addr_rs2, count, push_ready} !==
          {1'b0, 32'h0, NOP, 5'd0, 5'd0, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL rst_mid_after: got v=%0b pc=%08h inst=%08h rs1=%0d rs2=%0d cnt=%0d rdy=%0b want reset values",
                  valid_d, PC_d, inst_d, addr_rs1, addr_rs2, count, push_ready);
      end
   endtask

`ifdef FETCH_QUEUE_BYPASS_EN
   task automatic test_bypass();
      apply(1'b1, 32'h0000_1004, 32'h0020_8133, 1'b0, 1'b0);
      total++;
      if ({valid_d, PC_d, addr_rs1, addr_rs2, count} !== {1'b1, 32'h0000_1004, 5'd1, 5'd2, 3'd0}) begin
         bad++;
         $display("FAIL bypass_same_cycle: got v=%0b pc=%08h rs1=%0d rs2=%0d cnt=%0d want v=1 pc=00001004 rs1=1 rs2=2 cnt=0",
                  valid_d, PC_d, addr_rs1, addr_rs2, count);
      end
      step();
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      total++;
      if ({valid_d, count} !== {1'b0, 3'd0}) begin
         bad++;
         $display("FAIL bypass_consumed: got v=%0b cnt=%0d want v=0 cnt=0", valid_d, count);
      end
      step();
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      push_valid = 1'b0;
      PC_f       = '0;
      inst_f     = '0;
      stall      = 1'b0;
      kill_dx    = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_full_stall();
      test_kill();
      test_back_to_back();
      test_reset_mid();
`ifdef FETCH_QUEUE_BYPASS_EN
      test_bypass();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
